l1_miss_handler: RTL and testbench



---
 rtl/l1_miss_handler_pkg.sv | 18 +
 rtl/l1_miss_handler_if.sv | 36 +++
 rtl/l1_miss_handler_sat_counter.sv | 26 ++
 rtl/l1_miss_handler.sv | 138 +++++++++++++
 tb/tb_l1_miss_handler.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_miss_handler_pkg.sv
// Shared types and defaults for the L1 miss handler slice.
// State encodings are fixed at 3 bits so they line up with the cache config.
package l1_miss_handler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_L2_WAIT = 3'd2,
    ST_PROMOTE = 3'd3,
    ST_RESPOND = 3'd4
  } state_e;

  localparam int ADDR_WIDTH_DEF = 11;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int L2_TIMEOUT_DEF = 64;
  localparam int STAT_WIDTH_DEF = 16;

endpackage

// File: rtl/l1_miss_handler_if.sv
// CPU, L1 and L2 signal bundle around the miss handler.
// The handler uses the slave view; the surrounding system uses the master view.
interface l1_miss_handler_if
  import l1_miss_handler_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  cpu_req_valid;
  logic [ADDR_WIDTH-1:0] cpu_req_addr;
  logic                  cpu_req_ready;
  logic                  cpu_resp_valid;
  logic [DATA_WIDTH-1:0] cpu_resp_data;
  logic                  cpu_resp_error;
  logic [ADDR_WIDTH-1:0] l1_address;
  logic                  l1_hit;
  logic [DATA_WIDTH-1:0] l1_data;
  logic                  l1_promote;
  logic [DATA_WIDTH-1:0] l1_promotion_data;
  logic                  l2_req_valid;
  logic [ADDR_WIDTH-1:0] l2_req_addr;
  logic                  l2_resp_valid;
  logic [DATA_WIDTH-1:0] l2_resp_data;

  modport slave (
    input  cpu_req_valid, cpu_req_addr, l1_hit, l1_data, l2_resp_valid, l2_resp_data,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_error,
           l1_address, l1_promote, l1_promotion_data, l2_req_valid, l2_req_addr
  );

  modport master (
    output cpu_req_valid, cpu_req_addr, l1_hit, l1_data, l2_resp_valid, l2_resp_data,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_error,
           l1_address, l1_promote, l1_promotion_data, l2_req_valid, l2_req_addr
  );
endinterface

// File: rtl/l1_miss_handler_sat_counter.sv
// Saturating event counter used for the hit/miss statistics.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;

  // Count up on inc, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (inc && (count_r != '1)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
endmodule

// File: rtl/l1_miss_handler.sv
// Single-outstanding CPU read sequencer in front of the L1: hit return,
// L2 refill with one-cycle L1 promotion, and an L2 watchdog.
module l1_miss_handler
  import l1_miss_handler_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int L2_TIMEOUT = L2_TIMEOUT_DEF,
  parameter int STAT_WIDTH = STAT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  l1_miss_handler_if.slave      bus,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count
);
  localparam int TIMER_WIDTH = $clog2(L2_TIMEOUT);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(L2_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE  = TIMER_WIDTH'(1);

  state_e                 state_r;
  logic                   ready_r;
  logic                   resp_valid_r;
  logic [DATA_WIDTH-1:0]  resp_data_r;
  logic                   resp_error_r;
  logic [ADDR_WIDTH-1:0]  l1_addr_r;
  logic                   promote_r;
  logic [DATA_WIDTH-1:0]  promo_data_r;
  logic                   l2_req_valid_r;
  logic [ADDR_WIDTH-1:0]  l2_req_addr_r;
  logic [TIMER_WIDTH-1:0] timer_r;
  logic                   hit_inc_s;
  logic                   miss_inc_s;

  // The L1 answer is combinational on l1_address, so it is settled in LOOKUP.
  assign hit_inc_s  = (state_r == ST_LOOKUP) &&  bus.l1_hit;
  assign miss_inc_s = (state_r == ST_LOOKUP) && !bus.l1_hit;

  // Request FSM with watchdog timer and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      ready_r        <= 1'b0;
      resp_valid_r   <= 1'b0;
      resp_data_r    <= '0;
      resp_error_r   <= 1'b0;
      l1_addr_r      <= '0;
      promote_r      <= 1'b0;
      promo_data_r   <= '0;
      l2_req_valid_r <= 1'b0;
      l2_req_addr_r  <= '0;
      timer_r        <= '0;
    end else begin
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      promote_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          ready_r <= 1'b1;
          if (ready_r && bus.cpu_req_valid) begin
            l1_addr_r <= bus.cpu_req_addr;
            ready_r   <= 1'b0;
            state_r   <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (bus.l1_hit) begin
            resp_data_r  <= bus.l1_data;
            resp_valid_r <= 1'b1;
            ready_r      <= 1'b1;
            state_r      <= ST_IDLE;
          end else begin
            l2_req_valid_r <= 1'b1;
            l2_req_addr_r  <= l1_addr_r;
            timer_r        <= '0;
            state_r        <= ST_L2_WAIT;
          end
        end
        ST_L2_WAIT: begin
          // A response in the final watchdog cycle still completes normally.
          if (bus.l2_resp_valid) begin
            promo_data_r   <= bus.l2_resp_data;
            resp_data_r    <= bus.l2_resp_data;
            l2_req_valid_r <= 1'b0;
            promote_r      <= 1'b1;
            state_r        <= ST_PROMOTE;
          end else if (timer_r == TIMER_LAST) begin
            l2_req_valid_r <= 1'b0;
            resp_data_r    <= '0;
            resp_valid_r   <= 1'b1;
            resp_error_r   <= 1'b1;
            ready_r        <= 1'b1;
            state_r        <= ST_IDLE;
          end else begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end
        ST_PROMOTE: begin
          resp_valid_r <= 1'b1;
          state_r      <= ST_RESPOND;
        end
        ST_RESPOND: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          ready_r        <= 1'b0;
          l2_req_valid_r <= 1'b0;
          state_r        <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_req_ready     = ready_r;
  assign bus.cpu_resp_valid    = resp_valid_r;
  assign bus.cpu_resp_data     = resp_data_r;
  assign bus.cpu_resp_error    = resp_error_r;
  assign bus.l1_address        = l1_addr_r;
  assign bus.l1_promote        = promote_r;
  assign bus.l1_promotion_data = promo_data_r;
  assign bus.l2_req_valid      = l2_req_valid_r;
  assign bus.l2_req_addr       = l2_req_addr_r;

  sat_counter #(.WIDTH(STAT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_inc_s),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(STAT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_inc_s),
    .count (miss_count)
  );
endmodule

// File: tb/tb_l1_miss_handler.sv
// Scoreboard bench for l1_miss_handler with a behavioural L1 array and directed L2 replies.
module tb_l1_miss_handler;
  typedef struct packed {logic [31:0] data; logic error;} resp_t;
  typedef struct packed {logic [10:0] addr; logic [31:0] data;} promo_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] hit_count;
  logic [1:0] miss_count;
  int         checks = 0;
  int         errors = 0;
  int         hit_exp;

  resp_t  exp_q[$];
  promo_t promo_q[$];
  resp_t  mon_r;
  promo_t mon_p;

  logic        l1_clear;
  logic        preload_en;
  logic [10:0] preload_addr;
  logic [31:0] preload_data;
  logic [31:0] l1_mem [2048];
  logic        l1_vld [2048];

  l1_miss_handler_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus ();

  l1_miss_handler #(
    .ADDR_WIDTH(11), .DATA_WIDTH(32), .L2_TIMEOUT(8), .STAT_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // L1 model: combinational read, write on promotion at the closing edge.
  assign bus.l1_hit  = l1_vld[bus.l1_address];
  assign bus.l1_data = l1_mem[bus.l1_address];
  always @(posedge clk) begin
    if (l1_clear) begin
      for (int i = 0; i < 2048; i++) l1_vld[i] <= 1'b0;
    end else if (preload_en) begin
      l1_mem[preload_addr] <= preload_data;
      l1_vld[preload_addr] <= 1'b1;
    end else if (bus.l1_promote) begin
      l1_mem[bus.l1_address] <= bus.l1_promotion_data;
      l1_vld[bus.l1_address] <= 1'b1;
    end
  end

  task automatic chkv(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chkv(name, 64'(act), 64'(exp));
  endtask

  // Scoreboard monitor: every response and promotion must match a queued expectation.
  always @(negedge clk) begin
    if (!reset && bus.cpu_resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got data %0h err %0b expected no response",
                 bus.cpu_resp_data, bus.cpu_resp_error);
      end else begin
        mon_r = exp_q.pop_front();
        chkv("resp_data", 64'(bus.cpu_resp_data), 64'(mon_r.data));
        chk1("resp_error", bus.cpu_resp_error, mon_r.error);
      end
    end
    if (!reset && bus.l1_promote) begin
      if (promo_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_promote: got addr %0h data %0h expected none",
                 bus.l1_address, bus.l1_promotion_data);
      end else begin
        mon_p = promo_q.pop_front();
        chkv("promo_addr", 64'(bus.l1_address), 64'(mon_p.addr));
        chkv("promo_data", 64'(bus.l1_promotion_data), 64'(mon_p.data));
      end
    end
  end

  // Call at a negedge; issues the request and returns #1 after the accepting edge.
  task automatic request(input logic [10:0] addr);
    int n = 0;
    while (bus.cpu_req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("req_ready_wait", bus.cpu_req_ready, 1'b1);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = addr;
    @(posedge clk);
    #1 bus.cpu_req_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk1({tag, "_resp_valid"}, bus.cpu_resp_valid, 1'b0);
    chkv({tag, "_resp_data"}, 64'(bus.cpu_resp_data), 64'd0);
    chk1({tag, "_resp_error"}, bus.cpu_resp_error, 1'b0);
    chkv({tag, "_l1_address"}, 64'(bus.l1_address), 64'd0);
    chk1({tag, "_promote"}, bus.l1_promote, 1'b0);
    chkv({tag, "_promo_data"}, 64'(bus.l1_promotion_data), 64'd0);
    chk1({tag, "_l2_req_valid"}, bus.l2_req_valid, 1'b0);
    chkv({tag, "_l2_req_addr"}, 64'(bus.l2_req_addr), 64'd0);
    chkv({tag, "_hit_count"}, 64'(hit_count), 64'd0);
    chkv({tag, "_miss_count"}, 64'(miss_count), 64'd0);
  endtask

  task automatic l2_reply(input logic [31:0] data);
    bus.l2_resp_valid = 1'b1;
    bus.l2_resp_data  = data;
    @(posedge clk);
    #1 bus.l2_resp_valid = 1'b0;
    bus.l2_resp_data = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; l1_clear = 1'b1; preload_en = 1'b0;
    preload_addr = 11'd0; preload_data = 32'd0;
    bus.cpu_req_valid = 1'b0; bus.cpu_req_addr = 11'd0;
    bus.l2_resp_valid = 1'b0; bus.l2_resp_data = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("reset_ready", bus.cpu_req_ready, 1'b0);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0; l1_clear = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk1("post_reset_ready", bus.cpu_req_ready, 1'b1);
    check_outputs_zero("post_reset");

    preload_addr = 11'h123; preload_data = 32'hDEADBEEF; preload_en = 1'b1;
    @(posedge clk);
    #1 preload_en = 1'b0;

    // Hit: response two cycles after the accepting edge.
    exp_q.push_back({32'hDEADBEEF, 1'b0});
    @(negedge clk);
    request(11'h123);
    @(negedge clk);
    chk1("hit_c1_resp_valid", bus.cpu_resp_valid, 1'b0);
    chk1("hit_c1_l2_req", bus.l2_req_valid, 1'b0);
    @(negedge clk);
    chk1("hit_c2_resp_valid", bus.cpu_resp_valid, 1'b1);
    chkv("hit_count_1", 64'(hit_count), 64'd1);
    chk1("hit_c2_l2_req", bus.l2_req_valid, 1'b0);

    // Miss to 0x2A0 with L2 answering three cycles after the request rises.
    exp_q.push_back({32'hCAFEF00D, 1'b0});
    promo_q.push_back({11'h2A0, 32'hCAFEF00D});
    request(11'h2A0);
    @(negedge clk);
    chk1("miss_c1_l2_req", bus.l2_req_valid, 1'b0);
    @(negedge clk);
    chk1("miss_c2_l2_req", bus.l2_req_valid, 1'b1);
    chkv("miss_c2_l2_addr", 64'(bus.l2_req_addr), 64'h2A0);
    chkv("miss_count_1", 64'(miss_count), 64'd1);
    repeat (2) begin
      @(negedge clk);
      chk1("miss_wait_l2_req", bus.l2_req_valid, 1'b1);
      chk1("miss_wait_promote", bus.l1_promote, 1'b0);
    end
    @(negedge clk);
    l2_reply(32'hCAFEF00D);
    @(negedge clk);
    chk1("miss_c6_promote", bus.l1_promote, 1'b1);
    chk1("miss_c6_l2_req", bus.l2_req_valid, 1'b0);
    chk1("miss_c6_resp_valid", bus.cpu_resp_valid, 1'b0);
    @(negedge clk);
    chk1("miss_c7_resp_valid", bus.cpu_resp_valid, 1'b1);
    chk1("miss_c7_promote", bus.l1_promote, 1'b0);

    // Repeat of the promoted address now hits.
    exp_q.push_back({32'hCAFEF00D, 1'b0});
    request(11'h2A0);
    @(negedge clk);
    chk1("rehit_c1_l2_req", bus.l2_req_valid, 1'b0);
    @(negedge clk);
    chk1("rehit_c2_resp_valid", bus.cpu_resp_valid, 1'b1);
    chkv("hit_count_2", 64'(hit_count), 64'd2);

    // Timeout with a silent L2, plus requests presented while busy.
    exp_q.push_back({32'd0, 1'b1});
    request(11'h055);
    @(negedge clk);
    for (int cyc = 2; cyc <= 9; cyc++) begin
      @(negedge clk);
      chk1("to_wait_l2_req", bus.l2_req_valid, 1'b1);
      chk1("to_wait_resp_valid", bus.cpu_resp_valid, 1'b0);
      if (cyc >= 3 && cyc <= 5) chk1("busy_ready", bus.cpu_req_ready, 1'b0);
      if (cyc == 3) begin
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = 11'h123;
      end
      if (cyc == 5) bus.cpu_req_valid = 1'b0;
    end
    @(negedge clk);
    chk1("to_resp_valid", bus.cpu_resp_valid, 1'b1);
    chk1("to_resp_error", bus.cpu_resp_error, 1'b1);
    chk1("to_l2_req", bus.l2_req_valid, 1'b0);
    chk1("to_promote", bus.l1_promote, 1'b0);
    chkv("miss_count_2", 64'(miss_count), 64'd2);
    @(negedge clk);
    l2_reply(32'hBAD0BAD0);
    repeat (3) begin
      @(negedge clk);
      chk1("late_resp_valid", bus.cpu_resp_valid, 1'b0);
      chk1("late_promote", bus.l1_promote, 1'b0);
      chk1("late_ready", bus.cpu_req_ready, 1'b1);
    end

    // L2 reply in the final watchdog cycle completes normally.
    exp_q.push_back({32'h12345678, 1'b0});
    promo_q.push_back({11'h066, 32'h12345678});
    request(11'h066);
    @(negedge clk);
    @(negedge clk);
    chkv("miss_count_3", 64'(miss_count), 64'd3);
    repeat (6) @(negedge clk);
    @(negedge clk);
    l2_reply(32'h12345678);
    @(negedge clk);
    chk1("race_promote", bus.l1_promote, 1'b1);
    chk1("race_resp_valid", bus.cpu_resp_valid, 1'b0);
    @(negedge clk);
    chk1("race_resp_valid2", bus.cpu_resp_valid, 1'b1);
    chk1("race_resp_error", bus.cpu_resp_error, 1'b0);

    // Five back-to-back hits saturate the 2-bit hit counter at 3.
    hit_exp = 2;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({32'hDEADBEEF, 1'b0});
      request(11'h123);
      @(negedge clk);
      @(negedge clk);
      if (hit_exp < 3) hit_exp++;
      chkv("sat_hit_count", 64'(hit_count), 64'(hit_exp));
    end
    chkv("sat_hit_final", 64'(hit_count), 64'd3);

    // Reset in the middle of L2_WAIT abandons the transaction.
    request(11'h077);
    repeat (3) @(negedge clk);
    chk1("rst_pre_l2_req", bus.l2_req_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("rst_async_l2_req", bus.l2_req_valid, 1'b0);
    chk1("rst_async_promote", bus.l1_promote, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk1("rst_mid_ready", bus.cpu_req_ready, 1'b1);
    check_outputs_zero("rst_mid");
    repeat (3) @(negedge clk);

    chkv("resp_queue_empty", 64'(exp_q.size()), 64'd0);
    chkv("promo_queue_empty", 64'(promo_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
